evp_fsm: RTL

- Reader counterpart of the STP path. On start it reads slot A's coefficient count from N RAM and its coefficients from S RAM.
- It evaluates the polynomial at x using Horner's method and presents a 32-bit result and status for the result/status FIFOs.
- It sits beside the STP FSM in the instruction datapath and shares the S and N RAMs through their read ports.

---
 rtl/evp_fsm_if.sv | 30 +++
 rtl/evp_fsm.sv | 137 +++++++++++++
 2 files changed

// File: rtl/evp_fsm_if.sv
// Bus between the polynomial evaluator and its surroundings: instruction start,
// N/S RAM read ports and the result/status handoff.
interface evp_fsm_if #(
   parameter int word_size = 16,
   parameter int n_size    = 8,
   parameter int s_size    = 88
);
   logic                          start_evp;
   logic [$clog2(n_size)-1:0]     A;
   logic signed [word_size-1:0]   x;
   logic [4:0]                    rd_data_N;
   logic signed [word_size-1:0]   rd_data_S;
   logic                          en_rd_N;
   logic [$clog2(n_size)-1:0]     rd_addr_N;
   logic                          en_rd_S;
   logic [$clog2(s_size)-1:0]     rd_addr_S;
   logic                          done_evp;
   logic signed [31:0]            result;
   logic [31:0]                   status;

   modport master (
      output start_evp, A, x, rd_data_N, rd_data_S,
      input  en_rd_N, rd_addr_N, en_rd_S, rd_addr_S, done_evp, result, status
   );

   modport slave (
      input  start_evp, A, x, rd_data_N, rd_data_S,
      output en_rd_N, rd_addr_N, en_rd_S, rd_addr_S, done_evp, result, status
   );
endinterface

// File: rtl/evp_fsm.sv
// Polynomial evaluator: fetches slot A's coefficient count and coefficients from
// the shared N/S RAMs and evaluates them at x with Horner's method (32-bit wrap).
module evp_fsm #(
   parameter int word_size = 16,
   parameter int n_size    = 8,
   parameter int s_size    = 88
) (
   input logic     clk,
   input logic     rst,
   evp_fsm_if.slave bus
);
   localparam int AW_N  = $clog2(n_size);
   localparam int AW_S  = $clog2(s_size);
   localparam int MAX_N = 11;

   typedef enum logic [2:0] {IDLE, RD_N, CHK_N, LOAD, MAC, ERR, DONE} state_t;

   state_t                      state;
   logic [AW_S-1:0]             base;
   logic signed [word_size-1:0] x_q;
   logic [3:0]                  idx;
   logic signed [31:0]          acc;
   logic signed [31:0]          acc_next;
   logic signed [31:0]          result_q;
   logic [31:0]                 status_q;
   logic [1:0]                  err_code;
   logic                        en_n_q;
   logic [AW_N-1:0]             addr_n_q;
   logic                        en_s_q;
   logic [AW_S-1:0]             addr_s_q;
   logic                        done_q;
   logic                        n_ok;
   logic                        chk_rd;

   function automatic logic signed [31:0] sext_w(input logic signed [word_size-1:0] v);
      return {{(32-word_size){v[word_size-1]}}, v};
   endfunction

   // One Horner step, silently wrapped to 32 bits.
   function automatic logic signed [31:0] horner_step(input logic signed [31:0] a,
                                                      input logic signed [word_size-1:0] xv,
                                                      input logic signed [word_size-1:0] c);
      return a * sext_w(xv) + sext_w(c);
   endfunction

   assign n_ok   = (bus.rd_data_N != 5'd0) && (bus.rd_data_N <= 5'(MAX_N));
   assign chk_rd = (state == CHK_N) && n_ok;

   always_comb begin
      acc_next = horner_step(acc, x_q, bus.rd_data_S);
      if (state == LOAD)
         acc_next = sext_w(bus.rd_data_S);
   end

   // The first S read has to go out in the same cycle N arrives from the RAM's
   // output register; every later read is prepared one edge ahead.
   assign bus.en_rd_S   = en_s_q | chk_rd;
   assign bus.rd_addr_S = chk_rd ? base + AW_S'(bus.rd_data_N) - AW_S'(1) : addr_s_q;
   assign bus.en_rd_N   = en_n_q;
   assign bus.rd_addr_N = addr_n_q;
   assign bus.done_evp  = done_q;
   assign bus.result    = result_q;
   assign bus.status    = status_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         base     <= '0;
         x_q      <= '0;
         idx      <= '0;
         acc      <= '0;
         result_q <= '0;
         status_q <= 32'hFFFF_FFFF;
         err_code <= '0;
         en_n_q   <= 1'b0;
         addr_n_q <= '0;
         en_s_q   <= 1'b0;
         addr_s_q <= '0;
         done_q   <= 1'b0;
      end else begin
         en_n_q   <= 1'b0;
         addr_n_q <= '0;
         en_s_q   <= 1'b0;
         addr_s_q <= '0;
         done_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_evp) begin
                  base     <= AW_S'(bus.A) * AW_S'(MAX_N);
                  x_q      <= bus.x;
                  en_n_q   <= 1'b1;
                  addr_n_q <= bus.A;
                  state    <= RD_N;
               end
            end
            RD_N: state <= CHK_N;
            CHK_N: begin
               if (n_ok) begin
                  idx <= 4'(bus.rd_data_N - 5'd1);
                  if (bus.rd_data_N >= 5'd2) begin
                     en_s_q   <= 1'b1;
                     addr_s_q <= base + AW_S'(bus.rd_data_N) - AW_S'(2);
                  end
                  state <= LOAD;
               end else begin
                  err_code <= (bus.rd_data_N == 5'd0) ? 2'd1 : 2'd2;
                  state    <= ERR;
               end
            end
            LOAD, MAC: begin
               acc <= acc_next;
               if (idx == 4'd0) begin
                  result_q <= acc_next;
                  status_q <= 32'd0;
                  done_q   <= 1'b1;
                  state    <= DONE;
               end else begin
                  idx <= idx - 4'd1;
                  if (idx >= 4'd2) begin
                     en_s_q   <= 1'b1;
                     addr_s_q <= base + AW_S'(idx) - AW_S'(2);
                  end
                  state <= MAC;
               end
            end
            ERR: begin
               result_q <= '0;
               status_q <= 32'(err_code);
               done_q   <= 1'b1;
               state    <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
